// File: rtl/zbuffer_sequencer.sv
// Serial read-compare-write controller for a single-port synchronous z-buffer RAM.
// It handles one pixel at a time, runs a full-buffer clear sweep and keeps saturating statistics.
module zbuffer_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 8,
  parameter int COLOR_WIDTH = 8,
  parameter int PIXEL_WIDTH = ADDR_WIDTH + DEPTH_WIDTH + COLOR_WIDTH,
  parameter int CNT_WIDTH   = 16,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               send_z_buffer,
  input  logic [PIXEL_WIDTH-1:0]             pix_in,
  output logic                               rdy_z_buffer,
  input  logic                               clear_start,
  output logic                               clear_done,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic                               mem_rd_en,
  input  logic [DEPTH_WIDTH+COLOR_WIDTH-1:0] mem_rd_data,
  output logic                               mem_wr_en,
  output logic [DEPTH_WIDTH+COLOR_WIDTH-1:0] mem_wr_data,
  output logic [CNT_WIDTH-1:0]               stat_written,
  output logic [CNT_WIDTH-1:0]               stat_rejected
);

  localparam int DATA_WIDTH = DEPTH_WIDTH + COLOR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CMP,
    S_WR,
    S_CLEAR
  } state_t;

  state_t                  state_q;
  logic                    clear_pending_q;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q;
  logic [ADDR_WIDTH-1:0]   pix_addr_q;
  logic [DEPTH_WIDTH-1:0]  pix_depth_q;
  logic [COLOR_WIDTH-1:0]  pix_color_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_rd_en_q;
  logic                    mem_wr_en_q;
  logic [DATA_WIDTH-1:0]   mem_wr_data_q;
  logic                    clear_done_q;
  logic [CNT_WIDTH-1:0]    written_q;
  logic [CNT_WIDTH-1:0]    rejected_q;

  logic                    xfer;
  logic                    depth_wins;
  logic [ADDR_WIDTH-1:0]   in_addr;
  logic [DEPTH_WIDTH-1:0]  in_depth;
  logic [COLOR_WIDTH-1:0]  in_color;
  logic [CNT_WIDTH-1:0]    written_d;
  logic [CNT_WIDTH-1:0]    rejected_d;

  assign in_addr  = pix_in[PIXEL_WIDTH-1 -: ADDR_WIDTH];
  assign in_depth = pix_in[DATA_WIDTH-1 -: DEPTH_WIDTH];
  assign in_color = pix_in[COLOR_WIDTH-1:0];

  assign rdy_z_buffer = (state_q == S_IDLE) && !clear_pending_q;
  assign xfer         = send_z_buffer && rdy_z_buffer;

  // Padding the latched depth with all-ones colour makes this a strict depth-only
  // compare against the full stored word: ties in depth can never win.
  assign depth_wins = {pix_depth_q, {COLOR_WIDTH{1'b1}}} < mem_rd_data;

  assign written_d  = (written_q  == '1) ? written_q  : written_q  + CNT_WIDTH'(1);
  assign rejected_d = (rejected_q == '1) ? rejected_q : rejected_q + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      clear_pending_q <= 1'b0;
      clr_cnt_q       <= '0;
      pix_addr_q      <= '0;
      pix_depth_q     <= '0;
      pix_color_q     <= '0;
      mem_addr_q      <= '0;
      mem_rd_en_q     <= 1'b0;
      mem_wr_en_q     <= 1'b0;
      mem_wr_data_q   <= '0;
      clear_done_q    <= 1'b0;
      written_q       <= '0;
      rejected_q      <= '0;
    end else begin
      // NOTE: strobes default low every cycle so each one is a single-cycle pulse
      // unless the branch below re-asserts it; address and data simply hold.
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      clear_done_q <= 1'b0;

      if (clear_start && (state_q inside {S_RD, S_CMP, S_WR})) begin
        clear_pending_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            pix_addr_q  <= in_addr;
            pix_depth_q <= in_depth;
            pix_color_q <= in_color;
            mem_addr_q  <= in_addr;
            mem_rd_en_q <= 1'b1;
            state_q     <= S_RD;
            if (clear_start) begin
              clear_pending_q <= 1'b1;
            end
          end else if (clear_pending_q || clear_start) begin
            clear_pending_q <= 1'b0;
            clr_cnt_q       <= '0;
            written_q       <= '0;
            rejected_q      <= '0;
            mem_addr_q      <= '0;
            mem_wr_en_q     <= 1'b1;
            mem_wr_data_q   <= {{DEPTH_WIDTH{1'b1}}, CLEAR_COLOR};
            state_q         <= S_CLEAR;
          end
        end

        S_RD: begin
          state_q <= S_CMP;
        end

        S_CMP: begin
          if (depth_wins) begin
            mem_addr_q    <= pix_addr_q;
            mem_wr_en_q   <= 1'b1;
            mem_wr_data_q <= {pix_depth_q, pix_color_q};
            state_q       <= S_WR;
          end else begin
            rejected_q <= rejected_d;
            state_q    <= S_IDLE;
          end
        end

        S_WR: begin
          written_q <= written_d;
          state_q   <= S_IDLE;
        end

        S_CLEAR: begin
          // The counter tracks the address being written in the current cycle.
          if (clr_cnt_q == '1) begin
            clear_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            clr_cnt_q   <= clr_cnt_q + ADDR_WIDTH'(1);
            mem_addr_q  <= clr_cnt_q + ADDR_WIDTH'(1);
            mem_wr_en_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_rd_en     = mem_rd_en_q;
  assign mem_wr_en     = mem_wr_en_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign clear_done    = clear_done_q;
  assign stat_written  = written_q;
  assign stat_rejected = rejected_q;

endmodule

// File: tb/tb_zbuffer_sequencer.sv
// Self-checking bench for zbuffer_sequencer: directed table, multi-cycle corner cases and
// randomized pixels checked against a transaction-level z-buffer model.
module tb_zbuffer_sequencer;

  localparam int AW   = 4;
  localparam int DPW  = 8;
  localparam int CW   = 8;
  localparam int CNTW = 4;
  localparam int PW   = AW + DPW + CW;
  localparam int DW   = DPW + CW;
  localparam int N    = 1 << AW;
  localparam int SAT  = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            send_z_buffer;
  logic [PW-1:0]   pix_in;
  logic            rdy_z_buffer;
  logic            clear_start;
  logic            clear_done;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd_en;
  logic [DW-1:0]   mem_rd_data;
  logic            mem_wr_en;
  logic [DW-1:0]   mem_wr_data;
  logic [CNTW-1:0] stat_written;
  logic [CNTW-1:0] stat_rejected;

  always #5 clk = ~clk;

  zbuffer_sequencer #(
    .ADDR_WIDTH (AW),
    .DEPTH_WIDTH(DPW),
    .COLOR_WIDTH(CW),
    .CNT_WIDTH  (CNTW),
    .CLEAR_COLOR(8'h00)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .send_z_buffer(send_z_buffer),
    .pix_in       (pix_in),
    .rdy_z_buffer (rdy_z_buffer),
    .clear_start  (clear_start),
    .clear_done   (clear_done),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
    .stat_written (stat_written),
    .stat_rejected(stat_rejected)
  );

  // Single-port synchronous RAM: read data appears the cycle after the strobe.
  logic [DW-1:0] ram [N];
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
  end

  // Transaction-level reference: what the z-buffer should hold and the statistics.
  logic [DPW-1:0] ref_d [N];
  logic [CW-1:0]  ref_c [N];
  int             ref_w;
  int             ref_r;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  int xfer_cyc[$];
  always @(negedge clk) begin
    cyc++;
    if (rst_n && send_z_buffer && rdy_z_buffer) xfer_cyc.push_back(cyc);
    if (mem_rd_en || mem_wr_en) begin
      check("strobe_overlap", 32'(mem_rd_en && mem_wr_en), 0);
      check("rdy_while_busy", 32'(rdy_z_buffer), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      ref_d[i] = '1;
      ref_c[i] = '0;
    end
    ref_w = 0;
    ref_r = 0;
  endtask

  task automatic wait_rdy(input string name);
    int budget = 0;
    while (rdy_z_buffer !== 1'b1 && budget < 50) begin
      tick();
      budget++;
    end
    check(name, 32'(budget < 50), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},   32'(mem_rd_en), 0);
    check({tag, "_wr_en"},   32'(mem_wr_en), 0);
    check({tag, "_done"},    32'(clear_done), 0);
    check({tag, "_addr"},    32'(mem_addr), 0);
    check({tag, "_wr_data"}, 32'(mem_wr_data), 0);
    check({tag, "_written"}, 32'(stat_written), 0);
    check({tag, "_rejected"}, 32'(stat_rejected), 0);
  endtask

  // Called in the cycle of the first clear write; ends in the cycle after clear_done.
  task automatic check_sweep(input string tag);
    for (int k = 0; k < N; k++) begin
      check({tag, "_wr_en"},   32'(mem_wr_en), 1);
      check({tag, "_addr"},    32'(mem_addr), 32'(k));
      check({tag, "_data"},    32'(mem_wr_data), 32'h0000FF00);
      check({tag, "_rdy"},     32'(rdy_z_buffer), 0);
      check({tag, "_done_early"}, 32'(clear_done), 0);
      tick();
    end
    check({tag, "_done"},     32'(clear_done), 1);
    check({tag, "_end_wr"},   32'(mem_wr_en), 0);
    check({tag, "_written"},  32'(stat_written), 0);
    check({tag, "_rejected"}, 32'(stat_rejected), 0);
    tick();
    check({tag, "_done_pulse"}, 32'(clear_done), 0);
    check({tag, "_rdy_after"},  32'(rdy_z_buffer), 1);
    model_clear();
  endtask

  // Transfers one pixel and follows it through RD, CMP and (optionally) WR.
  task automatic send_pix(input logic [AW-1:0] a, input logic [DPW-1:0] d,
                          input logic [CW-1:0] c, input bit exp_wr);
    wait_rdy("pix_rdy_timeout");
    send_z_buffer = 1'b1;
    pix_in        = {a, d, c};
    tick();
    send_z_buffer = 1'b0;
    check("rd_en",   32'(mem_rd_en), 1);
    check("rd_addr", 32'(mem_addr), 32'(a));
    tick();
    check("cmp_strobes", 32'({mem_rd_en, mem_wr_en}), 0);
    tick();
    if (exp_wr) begin
      check("wr_en",   32'(mem_wr_en), 1);
      check("wr_addr", 32'(mem_addr), 32'(a));
      check("wr_data", 32'(mem_wr_data), 32'({d, c}));
      ref_d[a] = d;
      ref_c[a] = c;
      if (ref_w < SAT) ref_w++;
      tick();
    end else begin
      check("no_wr", 32'(mem_wr_en), 0);
      if (ref_r < SAT) ref_r++;
    end
    check("rdy_back",      32'(rdy_z_buffer), 1);
    check("stat_written",  32'(stat_written), 32'(ref_w));
    check("stat_rejected", 32'(stat_rejected), 32'(ref_r));
  endtask

  typedef struct {
    logic [AW-1:0]  a;
    logic [DPW-1:0] d;
    logic [CW-1:0]  c;
    bit             wr;
    int             written;
    int             rejected;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic [AW-1:0]  ra;
    logic [DPW-1:0] rd;
    bit             ew;
    int             i;
    int             budget;
    logic [AW-1:0]  b2b_a [4];

    tbl[0] = '{a: 4'h5, d: 8'h40, c: 8'hAA, wr: 1'b1, written: 1, rejected: 0};
    tbl[1] = '{a: 4'h5, d: 8'h40, c: 8'h55, wr: 1'b0, written: 1, rejected: 1};
    tbl[2] = '{a: 4'h5, d: 8'h3F, c: 8'h11, wr: 1'b1, written: 2, rejected: 1};
    tbl[3] = '{a: 4'h0, d: 8'hFF, c: 8'h77, wr: 1'b0, written: 2, rejected: 2};
    tbl[4] = '{a: 4'hF, d: 8'h00, c: 8'h01, wr: 1'b1, written: 3, rejected: 2};
    tbl[5] = '{a: 4'hF, d: 8'h00, c: 8'h02, wr: 1'b0, written: 3, rejected: 3};

    rst_n = 1'b0; send_z_buffer = 1'b0; clear_start = 1'b0; pix_in = '0;
    ref_w = 0; ref_r = 0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    check("rdy_after_reset", 32'(rdy_z_buffer), 1);

    // Post-reset clear sweep.
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check_sweep("sweep0");

    // Directed accept/reject/overwrite table.
    foreach (tbl[k]) begin
      send_pix(tbl[k].a, tbl[k].d, tbl[k].c, tbl[k].wr);
      check("tbl_written",  32'(stat_written),  32'(tbl[k].written));
      check("tbl_rejected", 32'(stat_rejected), 32'(tbl[k].rejected));
    end

    // Randomized pixels against the model; statistics run into saturation.
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      ra = AW'($urandom_range(0, N - 1));
      rd = DPW'($urandom_range(0, 255));
      ew = rd < ref_d[ra];
      send_pix(ra, rd, CW'($urandom), ew);
    end
    for (int k = 0; k < N; k++) check("ram_final", 32'(ram[k]), 32'({ref_d[k], ref_c[k]}));

    // clear_start in the same cycle as a transfer: pixel finishes, then the sweep.
    wait_rdy("coll0_rdy");
    ew = 8'h10 < ref_d[3];
    send_z_buffer = 1'b1; clear_start = 1'b1; pix_in = {4'h3, 8'h10, 8'h33};
    tick();
    send_z_buffer = 1'b0; clear_start = 1'b0;
    check("coll0_rd", 32'(mem_rd_en), 1);
    tick();
    tick();
    check("coll0_wr", 32'(mem_wr_en), 32'(ew));
    if (ew) tick();
    check("coll0_pend_rdy", 32'(rdy_z_buffer), 0);
    check("coll0_pend_wr",  32'(mem_wr_en), 0);
    send_z_buffer = 1'b1; pix_in = {4'h7, 8'h00, 8'hEE};
    tick();
    send_z_buffer = 1'b0;
    check_sweep("coll0");

    // Back-to-back stream with send held high.
    b2b_a = '{4'h1, 4'h2, 4'h4, 4'h8};
    xfer_cyc.delete();
    i = 0; budget = 0;
    send_z_buffer = 1'b1;
    pix_in = {b2b_a[0], 8'h20, 8'hA0};
    while (i < 4 && budget < 60) begin
      ew = rdy_z_buffer;
      tick();
      budget++;
      if (ew) begin
        i++;
        if (i < 4) pix_in = {b2b_a[i], 8'(8'h20 + i), 8'(8'hA0 + i)};
      end
    end
    send_z_buffer = 1'b0;
    check("b2b_budget", 32'(budget < 60), 1);
    wait_rdy("b2b_drain");
    check("b2b_count", 32'(xfer_cyc.size()), 4);
    for (int k = 1; k < xfer_cyc.size(); k++)
      check("b2b_spacing", 32'(xfer_cyc[k] - xfer_cyc[k-1]), 4);
    for (int k = 0; k < 4; k++) begin
      check("b2b_ram", 32'(ram[b2b_a[k]]), 32'({8'(8'h20 + k), 8'(8'hA0 + k)}));
      ref_d[b2b_a[k]] = 8'(8'h20 + k);
      ref_c[b2b_a[k]] = 8'(8'hA0 + k);
    end
    ref_w = 4;
    check("b2b_written", 32'(stat_written), 32'(ref_w));

    // clear_start during RD.
    wait_rdy("coll1_rdy");
    send_z_buffer = 1'b1; pix_in = {4'h6, 8'h05, 8'h66};
    tick();
    send_z_buffer = 1'b0; clear_start = 1'b1;
    check("coll1_rd", 32'(mem_rd_en), 1);
    tick();
    clear_start = 1'b0;
    tick();
    check("coll1_wr",   32'(mem_wr_en), 1);
    check("coll1_data", 32'(mem_wr_data), 32'h00000566);
    tick();
    check("coll1_pend_rdy", 32'(rdy_z_buffer), 0);
    check("coll1_written",  32'(stat_written), 5);
    send_z_buffer = 1'b1; pix_in = {4'h7, 8'h00, 8'hEE};
    tick();
    send_z_buffer = 1'b0;
    check_sweep("coll1");

    // Reset while a winning pixel sits in CMP.
    send_pix(4'h1, 8'h01, 8'h5A, 1'b1);
    wait_rdy("rstcmp_rdy");
    send_z_buffer = 1'b1; pix_in = {4'h9, 8'h10, 8'h99};
    tick();
    send_z_buffer = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("rstcmp");
    rst_n = 1'b1;
    tick();
    check("rstcmp_no_wr", 32'(mem_wr_en), 0);
    check("rstcmp_ram",   32'(ram[9]), 32'h0000FF00);
    check("rstcmp_rdy",   32'(rdy_z_buffer), 1);

    // Reset in the middle of a sweep.
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (5) tick();
    check("rstclr_in_sweep", 32'(mem_wr_en), 1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("rstclr");
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("rstclr_quiet", 32'({clear_done, mem_wr_en}), 0);
    end
    check("rstclr_rdy", 32'(rdy_z_buffer), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zbuffer_sequencer.md
# zbuffer_sequencer

Serial read-compare-write controller for the z-buffer memory. Accepts one packed pixel at a time from the contention tree's `send_z_buffer`/`pix_out` stream, reads the stored depth at the pixel address, and writes the pixel only if it is strictly closer. It also owns a full-buffer clear sweep and keeps accept/reject statistics. Sits between the contention tree and the single-port synchronous z-buffer RAM.

## Interface
- `ADDR_WIDTH`, default 8: z-buffer address bits. The buffer holds 2^ADDR_WIDTH entries.
- `DEPTH_WIDTH`, default 8: depth field bits. Smaller depth means closer.
- `COLOR_WIDTH`, default 8: color field bits.
- `PIXEL_WIDTH`, default ADDR_WIDTH+DEPTH_WIDTH+COLOR_WIDTH: packed pixel layout is {addr, depth, color}, with addr in the MSBs.
- `CNT_WIDTH`, default 16: width of the statistics counters.
- `CLEAR_COLOR`, default 0: color written during a clear sweep.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `send_z_buffer`  in  1  pixel valid from the contention tree.
- `pix_in`  in  PIXEL_WIDTH  packed pixel.
- `rdy_z_buffer`  out  1  ready. A pixel is transferred when `send_z_buffer` and `rdy_z_buffer` are both high.
- `clear_start`  in  1  one-cycle pulse that requests a clear sweep.
- `clear_done`  out  1  one-cycle pulse when the sweep ends.
- `mem_addr`  out  ADDR_WIDTH  RAM address.
- `mem_rd_en`  out  1  RAM read strobe. Data returns one cycle later.
- `mem_rd_data`  in  DEPTH_WIDTH+COLOR_WIDTH  RAM read data, {depth, color}.
- `mem_wr_en`  out  1  RAM write strobe.
- `mem_wr_data`  out  DEPTH_WIDTH+COLOR_WIDTH  RAM write data, {depth, color}.
- `stat_written`  out  CNT_WIDTH  number of pixels written.
- `stat_rejected`  out  CNT_WIDTH  number of pixels rejected by the depth test.

## Operation
**States:** IDLE, RD, CMP, WR, CLEAR.

**IDLE**
- `rdy_z_buffer` = 1 only when the state is IDLE and `clear_pending` = 0.
- On a transfer: latch addr, depth and color from `pix_in`, then go to RD.
- Otherwise, if `clear_pending` or `clear_start` is high: go to CLEAR.

**Clear requests**
- A `clear_start` that arrives while the block is in RD, CMP or WR, or in the same cycle as a transfer, sets the sticky `clear_pending` flag.
- `clear_pending` is served at the next IDLE, ahead of any new pixel.
- `clear_start` while in CLEAR is ignored.

**RD**
- `mem_rd_en` = 1 and `mem_addr` = latched address.
- Next state: CMP.

**CMP**
- `mem_rd_data` is valid in this cycle.
- If latched depth < stored depth (unsigned, strict): go to WR.
- Otherwise: `stat_rejected` += 1 and go to IDLE. Equal depth is rejected, so the first-drawn pixel wins.

**WR**
- `mem_wr_en` = 1, `mem_addr` = latched address, `mem_wr_data` = {latched depth, latched color}.
- `stat_written` += 1.
- Next state: IDLE.

**CLEAR**
- On entry: `clear_pending`, the clear counter, `stat_written` and `stat_rejected` are all set to 0.
- Each cycle: `mem_wr_en` = 1, `mem_addr` = counter, `mem_wr_data` = {all-ones depth, CLEAR_COLOR}. The counter then increments.
- After the write to address 2^ADDR_WIDTH−1: go to IDLE, and pulse `clear_done` for the following cycle only.

**Strobe and counter rules**
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle.
- Outside RD, WR and CLEAR, both strobes are 0, and `mem_addr`/`mem_wr_data` hold their last value.
- Both statistics counters saturate at 2^CNT_WIDTH−1 and do not wrap.

## Timing
**Pixel latency** (transfer at cycle t):
- Read strobe at t+1 and compare at t+2.
- Write at t+3, then ready again at t+4.
- A rejected pixel makes the block ready again at t+3.

**Throughput**
- One pixel every 4 cycles when written, every 3 cycles when rejected.
- Only one pixel is in flight at a time, so there are no read-after-write hazards.

**Clear timing**
- `clear_start` in IDLE at cycle t with no transfer: the first clear write is at t+1.
- The last write is at t+2^ADDR_WIDTH and `clear_done` pulses at t+2^ADDR_WIDTH+1.
- `rdy_z_buffer` is 0 for the whole sweep.

**Reset** (any rising edge with `rst_n` = 0, from any state):
- State = IDLE. `clear_pending` = 0. Clear counter and both statistics counters = 0.
- `mem_rd_en` = `mem_wr_en` = 0, `clear_done` = 0, `mem_addr` = 0, `mem_wr_data` = 0.
- `rdy_z_buffer` = 1 in the first cycle after reset is released.
- Reset mid-operation abandons the operation: no write is issued for a pixel caught in RD or CMP, and a sweep caught in CLEAR is left partial.

**Statistics update**
- Counters update at the clock edge that leaves CMP (reject) or leaves WR (write).

## Test plan
- **Post-reset clear, ADDR_WIDTH=4:** pulse `clear_start`.
  - Expect 16 consecutive writes to addresses 0..15, each with data {0xFF, 0x00}.
  - Expect `clear_done` exactly one cycle after the write to address 15, and `rdy_z_buffer` = 0 throughout the sweep.
- **Accept then reject:**
  - Send addr 5, depth 0x40, color 0xAA: expect a write of {0x40, 0xAA} to address 5 at t+3, and `stat_written` = 1.
  - Then send addr 5, depth 0x40: expect no write, `stat_rejected` = 1, and ready again at t+3.
- **Closer overwrite:** after the case above, send addr 5, depth 0x3F, color 0x11. Expect a write of {0x3F, 0x11} and `stat_written` = 2.
- **Back-to-back stream:** hold `send_z_buffer` high with 4 pixels to distinct addresses.
  - Expect `rdy_z_buffer` high only in IDLE, transfers spaced 4 cycles apart, and strobes never overlapping.
- **Clear collision:**
  - Pulse `clear_start` in the same cycle as a transfer: expect the pixel to finish RD/CMP/WR first, then CLEAR to start at the next IDLE with no new pixel accepted in between.
  - Pulse `clear_start` during RD: expect the same deferral.
- **Reset mid-operation:**
  - Drop `rst_n` while in CMP with a winning pixel: expect no write, and all outputs at their reset values.
  - Drop `rst_n` mid-CLEAR: expect the sweep to stop, no `clear_done`, and the counters to read 0.
